// File: rtl/x87_pkg.sv
// Shared x87 opcode constants and FIFO entry type.
// Used by the collect stage and the downstream decoder.
package x87_pkg;

    localparam logic [7:0] OP_FWAIT  = 8'h9B;
    localparam logic [7:0] OP_ESC_LO = 8'hD8;
    localparam logic [7:0] OP_ESC_HI = 8'hDF;

    localparam int X87_TAG_W = 32;

    typedef enum logic {
        S_OP1,
        S_OP2
    } x87_state_t;

    typedef struct packed {
        logic [7:0]           op1;
        logic [7:0]           op2;
        logic                 op2_valid;
        logic [X87_TAG_W-1:0] tag;
    } x87_entry_t;

    function automatic logic is_esc(input logic [7:0] b);
        return (b >= OP_ESC_LO) && (b <= OP_ESC_HI);
    endfunction

endpackage

// File: rtl/x87_op_collect_if.sv
// Byte-in / opcode-out handshake bundle of the x87 collect stage.
// slave = the collector, master = its environment.
interface x87_op_collect_if #(
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic [7:0]       in_byte;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_op1;
    logic [7:0]       out_op2;
    logic             out_op2_valid;
    logic             out_is_mem;
    logic [TAG_W-1:0] out_tag;
    logic             out_ready;
    logic             drop_pulse;
    logic [15:0]      drop_count;

    modport slave (
        input  flush, in_valid, in_byte, in_tag, out_ready,
        output in_ready, out_valid, out_op1, out_op2,
        output out_op2_valid, out_is_mem, out_tag,
        output drop_pulse, drop_count
    );

    modport master (
        output flush, in_valid, in_byte, in_tag, out_ready,
        input  in_ready, out_valid, out_op1, out_op2,
        input  out_op2_valid, out_is_mem, out_tag,
        input  drop_pulse, drop_count
    );
endinterface

// File: rtl/x87_op_fifo.sv
// Generic pointer-based synchronous FIFO with flush.
// DEPTH must be a power of two so pointers wrap naturally.
module x87_op_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/x87_op_collect.sv
// x87 opcode collector: assembles 1/2-byte x87 opcodes from the
// byte stream, queues them, and drops/counts non-x87 bytes.
module x87_op_collect
    import x87_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = X87_TAG_W
) (
    input  logic           clk,
    input  logic           rst_n,
    x87_op_collect_if.slave bus
);
    x87_state_t       state;
    x87_state_t       state_nxt;
    logic [7:0]       op1_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             latch;
    logic             drop_hit;
    logic             push;
    logic             pop;
    x87_entry_t       wentry;
    x87_entry_t       head;
    logic             full;
    logic             empty;
    logic [$clog2(DEPTH):0] count;
    logic             drop_pulse_q;
    logic [15:0]      drop_count_q;

    assign bus.in_ready = ~full & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_ready & ~empty & ~bus.flush;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        latch     = 1'b0;
        drop_hit  = 1'b0;
        wentry    = '0;
        if (bus.flush) begin
            state_nxt = S_OP1;
        end else if (accept) begin
            unique case (state)
                S_OP1: begin
                    unique case (1'b1)
                        (bus.in_byte == OP_FWAIT): begin
                            push       = 1'b1;
                            wentry.op1 = OP_FWAIT;
                            wentry.tag = bus.in_tag;
                        end
                        is_esc(bus.in_byte): begin
                            latch     = 1'b1;
                            state_nxt = S_OP2;
                        end
                        default: drop_hit = 1'b1;
                    endcase
                end
                S_OP2: begin
                    push             = 1'b1;
                    wentry.op1       = op1_q;
                    wentry.op2       = bus.in_byte;
                    wentry.op2_valid = 1'b1;
                    wentry.tag       = tag_q;
                    state_nxt        = S_OP1;
                end
                default: state_nxt = S_OP1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_OP1;
            op1_q        <= '0;
            tag_q        <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state        <= state_nxt;
            drop_pulse_q <= drop_hit;
            if (latch) begin
                op1_q <= bus.in_byte;
                tag_q <= bus.in_tag;
            end
            if (drop_hit && drop_count_q != 16'hFFFF)
                drop_count_q <= drop_count_q + 16'd1;
        end
    end

    x87_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(x87_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // count is exported by the FIFO for other users; not needed here.
    logic unused_count;
    assign unused_count = ^count;

    assign bus.out_valid     = ~empty;
    assign bus.out_op1       = empty ? 8'h00 : head.op1;
    assign bus.out_op2       = empty ? 8'h00 : head.op2;
    assign bus.out_op2_valid = ~empty & head.op2_valid;
    assign bus.out_is_mem    = ~empty & head.op2_valid
                             & (head.op2[7:6] != 2'b11);
    assign bus.out_tag       = empty ? '0 : head.tag;
    assign bus.drop_pulse    = drop_pulse_q;
    assign bus.drop_count    = drop_count_q;

endmodule
